tia_poly_counter: RTL
=====================

TIA_POLY_COUNTER -- requirements
Module: tia_poly_counter

Interface
REQ-001 Parameter WIDTH, default 6: number of two-phase stages (polynomial counter bits), range 2..16.
REQ-002 Parameter TAP_A, default 5: first feedback tap index, 0..WIDTH-1.
REQ-003 Parameter TAP_B, default 4: second feedback tap index, 0..WIDTH-1, != TAP_A.
REQ-004 Parameter TERMINAL, default 6'b111101: count value that forces a wrap to zero; must not be all-ones.
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  advance enable; low freezes all state, including the phase.
REQ-008 clear  input  1  synchronous counter reset (RSYNC-style).
REQ-009 q  output  WIDTH  counter state (phase-2 outputs of all stages).
REQ-010 tap  output  WIDTH  inverted middle state of each stage (phase-1 latch).
REQ-011 phase  output  1  0 = next enabled edge is phase-1 (sample), 1 = phase-2 (transfer).
REQ-012 wrap  output  1  high while q == TERMINAL.

Function
REQ-013 The block SHALL derive both stage phases from clk via the internal phase bit: it toggles on every rising edge with en=1 and clear=0.
REQ-014 Feedback SHALL be fb = ~(q[TAP_A] ^ q[TAP_B]) (XNOR), so all-zeros is a legal state.
REQ-015 Phase-1 edge (phase=0, en=1, clear=0): tap SHALL load ~{q[WIDTH-2:0], fb} if q != TERMINAL, else all-ones (inverted zero).
REQ-016 Phase-2 edge (phase=1, en=1, clear=0): q SHALL load ~tap; tap is held.
REQ-017 One counter step SHALL take exactly 2 enabled clocks; q changes only on phase-2 edges.
REQ-018 Period SHALL be (number of steps from zero to TERMINAL) + 1 steps; the step after TERMINAL is zero.
REQ-019 wrap SHALL be a decode of registered q only: glitch-free, high for exactly one step (2 enabled clocks) per period.
REQ-020 en=0 SHALL hold q, tap and phase indefinitely; the step resumes mid-phase when en returns.
REQ-021 clear=1 at an edge SHALL set q=0, tap=all-ones and phase=0, regardless of en or current phase (clear has priority over en).
REQ-022 clear held for several cycles SHALL keep the counter at zero; counting restarts with a phase-1 edge on the first enabled edge after release.
REQ-023 The all-ones state (XNOR lock-up) SHALL only be reachable by parameter misuse; clear SHALL recover it.

Reset
REQ-024 reset_n=0 SHALL immediately, without clk, force q=0, tap=all-ones, phase=0, wrap=0.
REQ-025 Reset assertion mid-step SHALL discard the pending phase-1 sample; release SHALL be followed by a phase-1 edge first.
REQ-026 No output SHALL be X after reset, in simulation or synthesis.

Structure
REQ-027 The shared TIA defines include SHALL hold the default WIDTH, tap indices and TERMINAL constants, plus the phase encodings.
REQ-028 One sub-module, tia_d2n_stage (one two-phase stage: sample enable, transfer enable, tap, out), SHALL be instantiated WIDTH times via generate.
REQ-029 Feedback, terminal decode and phase logic SHALL live in tia_poly_counter; elaboration-time checks SHALL reject illegal parameters (REQ-001..004).

Verification (defaults, all-zero start)
REQ-030 Release reset, en=1 -> q steps 000000,000001,000011,000111,001111,011111,111110,111101,000000, one value per 2 clocks.
REQ-031 Same run -> wrap high exactly while q=111101 (2 clocks), period 16 clocks; tap equals ~next-q after each phase-1 edge.
REQ-032 en dropped after a phase-1 edge at q=000011 for 5 clocks -> q, tap, phase frozen; next enabled edge loads q=000111.
REQ-033 clear pulsed at q=011111 on a phase-1 edge -> next cycle q=0, tap=111111, phase=0; sequence restarts at 000001 after 2 enabled clocks.
REQ-034 reset_n pulsed low between clk edges at q=001111 -> outputs reset asynchronously; first post-release phase-2 edge yields q=000001.
REQ-035 WIDTH=4, TAP_A=3, TAP_B=2, TERMINAL=4'b0111 -> q 0000,0001,0011,0111,0000; wrap period 8 clocks.

Source files
------------

// File: rtl/tia_poly_counter_pkg.sv
// rtl/tia_poly_counter_pkg.sv - shared TIA polynomial counter defaults and phase encodings
package tia_poly_counter_pkg;

  localparam int         DEFAULT_WIDTH    = 6;
  localparam int         DEFAULT_TAP_A    = 5;
  localparam int         DEFAULT_TAP_B    = 4;
  localparam logic [5:0] DEFAULT_TERMINAL = 6'b111101;

  typedef enum logic {
    PH_SAMPLE   = 1'b0,
    PH_TRANSFER = 1'b1
  } phase_e;

endpackage

// File: rtl/tia_poly_counter_if.sv
// rtl/tia_poly_counter_if.sv - control and status bundle of the polynomial counter
interface tia_poly_counter_if #(
  parameter int WIDTH = 6
);
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tap;
  logic             phase;
  logic             wrap;

  modport master (output en, output clear, input q, input tap, input phase, input wrap);
  modport slave  (input en, input clear, output q, output tap, output phase, output wrap);
endinterface

// File: rtl/tia_d2n_stage.sv
// rtl/tia_d2n_stage.sv - one two-phase stage: inverting sample latch feeding an inverting transfer
module tia_d2n_stage (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic sample,
  input  logic transfer,
  input  logic d,
  output logic tap,
  output logic out
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap <= 1'b1;
      out <= 1'b0;
    end else if (clear) begin
      tap <= 1'b1;
      out <= 1'b0;
    end else begin
      if (sample)   tap <= ~d;
      if (transfer) out <= ~tap;
    end
  end

endmodule

// File: rtl/tia_poly_counter.sv
// rtl/tia_poly_counter.sv - XNOR-feedback polynomial counter built from two-phase stages
module tia_poly_counter
  import tia_poly_counter_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               TAP_A    = DEFAULT_TAP_A,
  parameter int               TAP_B    = DEFAULT_TAP_B,
  parameter logic [WIDTH-1:0] TERMINAL = WIDTH'(DEFAULT_TERMINAL)
) (
  input logic             clk,
  input logic             reset_n,
  tia_poly_counter_if.slave bus
);

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("tia_poly_counter: WIDTH must be 2..16");
    end
    if (TAP_A < 0 || TAP_A >= WIDTH || TAP_B < 0 || TAP_B >= WIDTH) begin : g_bad_tap
      $error("tia_poly_counter: tap index out of range");
    end
    if (TAP_A == TAP_B) begin : g_same_tap
      $error("tia_poly_counter: TAP_A and TAP_B must differ");
    end
    if (TERMINAL == {WIDTH{1'b1}}) begin : g_bad_terminal
      $error("tia_poly_counter: TERMINAL must not be the XNOR lock-up state");
    end
  endgenerate

  phase_e           phase_q;
  phase_e           phase_d;
  logic             sample;
  logic             transfer;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tap_n;
  logic [WIDTH-1:0] d;
  logic             fb;
  logic             terminal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= PH_SAMPLE;
    else          phase_q <= phase_d;
  end

  // clear outranks en so a held clear always lands on a fresh phase-1
  always_comb begin
    phase_d  = phase_q;
    sample   = 1'b0;
    transfer = 1'b0;
    if (bus.clear) begin
      phase_d = PH_SAMPLE;
    end else if (bus.en) begin
      case (phase_q)
        PH_SAMPLE: begin
          sample  = 1'b1;
          phase_d = PH_TRANSFER;
        end
        PH_TRANSFER: begin
          transfer = 1'b1;
          phase_d  = PH_SAMPLE;
        end
        default: phase_d = PH_SAMPLE;
      endcase
    end
  end

  assign fb       = ~(q[TAP_A] ^ q[TAP_B]);
  assign terminal = (q == TERMINAL);
  assign d        = terminal ? '0 : {q[WIDTH-2:0], fb};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tia_d2n_stage u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (bus.clear),
      .sample   (sample),
      .transfer (transfer),
      .d        (d[i]),
      .tap      (tap_n[i]),
      .out      (q[i])
    );
  end

  assign bus.q     = q;
  assign bus.tap   = tap_n;
  assign bus.phase = phase_q;
  assign bus.wrap  = terminal;

endmodule
